// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped countdown timer on the CPU data-memory port.
// A 16-byte window at BASE exposes CTRL (idx 0), PRESET (idx 1), COUNT (idx 2)
// and a reserved slot (idx 3). Loads are answered combinationally; word stores
// land on the rising edge. The counter runs one-shot or auto-reload and raises
// FLAG on expiry; IRQ is FLAG gated by the interrupt mask.
module mmio_timer #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Ad,
  input  logic [31:0] WrData,
  input  logic [2:0]  MemWr,
  output logic [31:0] DM,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_CNT  = 2'b10,
    ST_INT  = 2'b11
  } state_t;

  localparam logic [1:0] IDX_CTRL   = 2'd0;
  localparam logic [1:0] IDX_PRESET = 2'd1;
  localparam logic [1:0] IDX_COUNT  = 2'd2;
  localparam logic [1:0] MODE_AUTO  = 2'b01;

  state_t      r_state;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_flag;

  logic        w_hit;
  logic [1:0]  w_idx;
  logic        w_store;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic [3:0]  w_ctrl_eff;
  logic        w_en_eff;
  logic        w_reload_eff;
  logic [31:0] w_rdata;
  logic        w_unused;

  // Byte-lane bits of the address play no part in register selection.
  assign w_unused = ^Ad[1:0];

  assign w_hit       = (Ad[31:4] == BASE[31:4]);
  assign w_idx       = Ad[3:2];
  assign w_store     = w_hit && (MemWr == 3'b001);
  assign w_wr_ctrl   = w_store && (w_idx == IDX_CTRL);
  assign w_wr_preset = w_store && (w_idx == IDX_PRESET);

  // A CTRL store on this edge overrides the current CTRL for FSM decisions.
  assign w_ctrl_eff   = w_wr_ctrl ? WrData[3:0] : r_ctrl;
  assign w_en_eff     = w_ctrl_eff[0];
  assign w_reload_eff = (w_ctrl_eff[2:1] == MODE_AUTO);

  // Read mux: zero outside the window and for the reserved slot.
  always_comb begin
    w_rdata = 32'd0;
    if (w_hit) begin
      case (w_idx)
        IDX_CTRL:   w_rdata = {28'd0, r_ctrl};
        IDX_PRESET: w_rdata = r_preset;
        IDX_COUNT:  w_rdata = r_count;
        default:    w_rdata = 32'd0;
      endcase
    end else begin
      w_rdata = 32'd0;
    end
  end

  assign DM  = w_rdata;
  assign IRQ = r_flag & r_ctrl[3];

  // Register file and countdown FSM; software stores take priority over the FSM.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state  <= ST_IDLE;
      r_ctrl   <= 4'd0;
      r_preset <= 32'd0;
      r_count  <= 32'd0;
      r_flag   <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl <= WrData[3:0];
      end
      if (w_wr_preset) begin
        r_preset <= WrData;
      end

      if (w_wr_preset) begin
        // Restart: the pending state action is dropped and the count reloads.
        r_state <= ST_LOAD;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_en_eff) begin
              r_state <= ST_LOAD;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_LOAD: begin
            r_count <= r_preset;
            r_state <= ST_CNT;
          end
          ST_CNT: begin
            if (!w_en_eff) begin
              r_state <= ST_CNT;
            end else if (r_count > 32'd1) begin
              r_count <= r_count - 32'd1;
            end else begin
              // Covers PRESET=0 too: expiry never wraps below zero.
              r_count <= 32'd0;
              r_flag  <= 1'b1;
              r_state <= ST_INT;
            end
          end
          ST_INT: begin
            if (w_reload_eff && w_en_eff) begin
              r_state <= ST_LOAD;
            end else begin
              if (!w_wr_ctrl) begin
                r_ctrl[0] <= 1'b0;
              end
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end

      // Software clear beats a same-edge expiry.
      if (w_wr_ctrl || w_wr_preset) begin
        r_flag <= 1'b0;
      end
    end
  end

endmodule
